// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the 16-bit SRAM data-memory controller.
// Holds the FSM state encoding and the byte-address to word-index mapping.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
   localparam int          HW_W          = 16;
   localparam int          CNT_W         = 4;

   // Wraparound subtraction keeps out-of-range addresses silently aliased.
   function automatic logic [31:0] word_index(
      input logic [31:0] i_addr,
      input logic [31:0] i_base
   );
      logic [31:0] w_diff;
      w_diff = i_addr - i_base;
      return w_diff >> 2;
   endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable down-counter timing each 16-bit SRAM phase.
// Load has priority over decrement; o_zero flags the last cycle of a phase.
module sram_phase_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_dec,
   output logic          o_zero
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory front end: one 32-bit access becomes two 16-bit
// SRAM phases (low then high half); ready low freezes the pipeline.
module sram_mem_controller
   import sram_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          WAIT_CYCLES = 2,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        address,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [HW_W-1:0]    sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [HW_W-1:0]    sram_dq_in,
   output logic               sram_we_n
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

   state_e r_state;
   state_e w_state_nx;

   logic               w_req;
   logic               w_accept;
   logic               w_load;
   logic               w_dec;
   logic               w_zero;
   logic               w_ready;
   logic               w_lo_end;
   logic               w_hi_end;
   logic [SRAM_AW-2:0] w_word_in;

   logic [SRAM_AW-2:0] r_word;
   logic [31:0]        r_wdata;
   logic               r_is_write;
   logic [31:0]        r_rdata;
   logic [SRAM_AW-1:0] r_sram_addr;
   logic [HW_W-1:0]    r_dq_out;
   logic               r_oe;
   logic               r_we_n;

   assign w_req     = MEM_R_EN | MEM_W_EN;
   assign w_word_in = (SRAM_AW-1)'(word_index(address, BASE_ADDR));
   assign w_lo_end  = (r_state == LO) && w_zero;
   assign w_hi_end  = (r_state == HI) && w_zero;

   sram_phase_counter #(
      .CW(CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_load_val(LOAD_VAL),
      .i_dec     (w_dec),
      .o_zero    (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_ready    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ready = ~w_req;
            if (w_req) begin
               w_accept   = 1'b1;
               w_load     = 1'b1;
               w_state_nx = LO;
            end
         end
         LO: begin
            if (w_zero) begin
               w_load     = 1'b1;
               w_state_nx = HI;
            end else begin
               w_dec = 1'b1;
            end
         end
         HI: begin
            if (w_zero) begin
               w_state_nx = DONE;
            end else begin
               w_dec = 1'b1;
            end
         end
         DONE: begin
            w_ready    = 1'b1;
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // SRAM pins are registered from the next phase so they line up with LO/HI.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word      <= '0;
         r_wdata     <= '0;
         r_is_write  <= 1'b0;
         r_rdata     <= '0;
         r_sram_addr <= '0;
         r_dq_out    <= '0;
         r_oe        <= 1'b0;
         r_we_n      <= 1'b1;
      end else if (w_accept) begin
         r_word      <= w_word_in;
         r_wdata     <= wdata;
         r_is_write  <= MEM_W_EN;
         r_sram_addr <= {w_word_in, 1'b0};
         r_dq_out    <= wdata[15:0];
         r_oe        <= MEM_W_EN;
         r_we_n      <= ~MEM_W_EN;
      end else if (w_lo_end) begin
         if (!r_is_write) begin
            r_rdata[15:0] <= sram_dq_in;
         end
         r_sram_addr <= {r_word, 1'b1};
         r_dq_out    <= r_wdata[31:16];
      end else if (w_hi_end) begin
         if (!r_is_write) begin
            r_rdata[31:16] <= sram_dq_in;
         end
         r_oe   <= 1'b0;
         r_we_n <= 1'b1;
      end
   end

   assign ready       = w_ready;
   assign rdata       = r_rdata;
   assign sram_addr   = r_sram_addr;
   assign sram_dq_out = r_dq_out;
   assign sram_dq_oe  = r_oe;
   assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: a W=2 and a W=1 instance, each on its own
// behavioural SRAM, checked against a word-level reference memory.
module tb_sram_mem_controller;

   localparam int AW = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          tb_rst   [2];
   logic          tb_ren   [2];
   logic          tb_wen   [2];
   logic [31:0]   tb_addr  [2];
   logic [31:0]   tb_wdata [2];
   logic [31:0]   tb_rdata [2];
   logic          tb_ready [2];
   logic [AW-1:0] tb_sa    [2];
   logic [15:0]   tb_dqo   [2];
   logic          tb_oe    [2];
   logic [15:0]   tb_dqi   [2];
   logic          tb_we_n  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      bit [15:0] mem [0:(2**AW)-1];

      sram_mem_controller #(
         .BASE_ADDR  (32'd1024),
         .WAIT_CYCLES((g == 0) ? 2 : 1),
         .SRAM_AW    (AW)
      ) u_dut (
         .clk        (clk),
         .rst        (tb_rst[g]),
         .MEM_R_EN   (tb_ren[g]),
         .MEM_W_EN   (tb_wen[g]),
         .address    (tb_addr[g]),
         .wdata      (tb_wdata[g]),
         .rdata      (tb_rdata[g]),
         .ready      (tb_ready[g]),
         .sram_addr  (tb_sa[g]),
         .sram_dq_out(tb_dqo[g]),
         .sram_dq_oe (tb_oe[g]),
         .sram_dq_in (tb_dqi[g]),
         .sram_we_n  (tb_we_n[g])
      );

      assign tb_dqi[g] = mem[tb_sa[g]];

      always @(posedge clk) begin
         if (!tb_we_n[g]) mem[tb_sa[g]] <= tb_dqo[g];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ref_mem [int unsigned];
   logic [31:0] exp_rd  [2];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int unsigned key(input int d, input logic [16:0] w);
      return d * (2**17) + int'(w);
   endfunction

   // Full access: drive in IDLE (cycle 0), check every cycle up to DONE.
   task automatic access(input int d, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd);
      int          w;
      bit          is_w;
      logic [16:0] word;
      logic [31:0] exp_addr;
      w    = (d == 0) ? 2 : 1;
      is_w = wr;
      word = 17'((a - 32'd1024) >> 2);
      @(posedge clk); #1;
      tb_ren[d] = rd; tb_wen[d] = wr;
      tb_addr[d] = a; tb_wdata[d] = wd;
      #1;
      check("ready_c0", 32'(tb_ready[d]), 32'd0);
      for (int k = 1; k <= 2 * w + 1; k++) begin
         @(posedge clk); #1;
         check("ready", 32'(tb_ready[d]), 32'(k == 2 * w + 1));
         check("we_n", 32'(tb_we_n[d]), 32'(!(is_w && k <= 2 * w)));
         check("oe", 32'(tb_oe[d]), 32'(is_w && k <= 2 * w));
         if (k <= 2 * w) begin
            exp_addr = 32'(word) * 2 + 32'(k > w);
            check("sram_addr", 32'(tb_sa[d]), exp_addr);
         end
         if (k == 2 * w + 1) begin
            if (is_w) begin
               ref_mem[key(d, word)] = wd;
            end else if (ref_mem.exists(key(d, word))) begin
               exp_rd[d] = ref_mem[key(d, word)];
            end else begin
               exp_rd[d] = 32'd0;
            end
            check(is_w ? "rdata_wr" : "rdata_rd", tb_rdata[d], exp_rd[d]);
         end
      end
      tb_ren[d] = 1'b0; tb_wen[d] = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(7) == 0)
         a = 32'd1024 - 32'd4 * (1 + $urandom_range(3));
      else
         a = 32'd1024 + 32'd4 * $urandom_range(63);
      return a + 32'($urandom_range(3));
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         tb_rst[d] = 1'b1; tb_ren[d] = 1'b0; tb_wen[d] = 1'b0;
         tb_addr[d] = '0; tb_wdata[d] = '0;
         exp_rd[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      tb_rst[0] = 1'b0; tb_rst[1] = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("rst_ready", 32'(tb_ready[0]), 32'd1);
         check("rst_we_n", 32'(tb_we_n[0]), 32'd1);
         check("rst_oe", 32'(tb_oe[0]), 32'd0);
         check("rst_rdata", tb_rdata[0], 32'd0);
      end

      access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
      check("mem_lo", 32'(g_dut[0].mem[2]), 32'h0000BEEF);
      check("mem_hi", 32'(g_dut[0].mem[3]), 32'h0000DEAD);
      access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
      check("readback", tb_rdata[0], 32'hDEADBEEF);

      access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
      check("both_rdata", tb_rdata[0], 32'hDEADBEEF);
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      check("both_read", tb_rdata[0], 32'h12345678);

      // Abort a write during its HI phase, then confirm normal operation.
      @(posedge clk); #1;
      tb_wen[0] = 1'b1; tb_addr[0] = 32'd1024 + 32'd800;
      tb_wdata[0] = 32'hA5A5_5A5A;
      repeat (3) @(posedge clk);
      #1;
      check("abort_in_hi", 32'(tb_sa[0]), 32'd401);
      tb_rst[0] = 1'b1; tb_wen[0] = 1'b0;
      @(posedge clk); #1;
      tb_rst[0] = 1'b0;
      exp_rd[0] = 32'd0;
      check("abort_ready", 32'(tb_ready[0]), 32'd1);
      check("abort_we_n", 32'(tb_we_n[0]), 32'd1);
      check("abort_oe", 32'(tb_oe[0]), 32'd0);
      check("abort_rdata", tb_rdata[0], 32'd0);
      access(0, 1'b0, 1'b1, 32'd1036, 32'hCAFE_F00D);
      access(0, 1'b1, 1'b0, 32'd1036, 32'h0);
      check("post_abort", tb_rdata[0], 32'hCAFEF00D);

      access(1, 1'b0, 1'b1, 32'd1024, 32'h1111_2222);
      access(1, 1'b0, 1'b1, 32'd1032, 32'h3333_4444);
      access(1, 1'b1, 1'b0, 32'd1024, 32'h0);
      check("b2b_rd0", tb_rdata[1], 32'h11112222);
      access(1, 1'b1, 1'b0, 32'd1032, 32'h0);
      check("b2b_rd1", tb_rdata[1], 32'h33334444);

      for (int i = 0; i < 60; i++) begin
         int          d;
         int          op;
         logic [31:0] a;
         d  = $urandom_range(1);
         op = $urandom_range(4);
         a  = rand_addr();
         access(d, op != 0, op <= 1, a, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit SRAM. It replaces the single-cycle data memory.
- Accepts one 32-bit read or write per request and splits it into two 16-bit SRAM phases (low half, then high half).
- Drives `ready` low while busy; the hazard/pipeline logic uses `~ready` as the pipeline freeze.
- The MEM stage holds its request stable while `ready` is low.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles per 16-bit SRAM phase; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- MEM_R_EN  in  1  read request
- MEM_W_EN  in  1  write request
- address  in  32  byte address from the ALU result
- wdata  in  32  store data (Val_Rm)
- rdata  out  32  read result, registered
- ready  out  1  1 = idle or completing; 0 = pipeline must freeze
- sram_addr  out  SRAM_AW  SRAM half-word address
- sram_dq_out  out  16  write data to the SRAM
- sram_dq_oe  out  1  drive enable for the external tristate
- sram_dq_in  in  16  read data from the SRAM
- sram_we_n  out  1  active-low write enable

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - State: IDLE.
  - rdata = 0, sram_addr = 0, sram_dq_out = 0.
  - sram_dq_oe = 0, sram_we_n = 1.
  - ready = 1 (ready is combinational from state and request).
- Reset mid-operation aborts the access immediately; no partial-write cleanup is done.
- Request: req = MEM_R_EN | MEM_W_EN. If both are high, the access is treated as a write.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, 32-bit wraparound subtraction.
  - Low half-word address = {word[SRAM_AW-2:0], 0}; high half-word address = {word[SRAM_AW-2:0], 1}.
  - Upper bits are truncated, so out-of-range addresses wrap silently.
  - address[1:0] is ignored.
- Latches on accepting a request in IDLE: address, wdata and the is_write flag are captured.
- States:
  - IDLE: ready = ~req. If req, capture the request, load cnt = WAIT_CYCLES-1, go to LO.
  - LO: sram_addr = low address. For a write: sram_dq_out = wdata[15:0], sram_dq_oe = 1, sram_we_n = 0. For a read: oe = 0, we_n = 1. When cnt == 0: a read samples sram_dq_in into rdata[15:0]; reload cnt and go to HI. Otherwise decrement cnt.
  - HI: same as LO with the high address and wdata[31:16]. When cnt == 0: a read samples into rdata[31:16]; go to DONE.
  - DONE: ready = 1, SRAM lines idle (oe = 0, we_n = 1). Next state is always IDLE, so a still-asserted request is not re-accepted in this cycle.
- SRAM outputs are registered: they are valid in the same cycles the state is LO/HI, driven from captured values.
- Latency, with a request seen in IDLE at cycle 0:
  - LO occupies cycles 1..W, HI occupies cycles W+1..2W, DONE is cycle 2W+1.
  - ready = 0 on cycles 0..2W; ready = 1 on cycle 2W+1.
  - Default W = 2: ready returns at cycle 5.
- Back-to-back requests: after DONE the pipeline advances. A new request seen in IDLE is accepted with ready dropping in that same cycle, giving a 1-cycle IDLE gap.
- rdata holds its value until the next read completes. Writes never change rdata.
- Request deassertion while busy is illegal (frozen pipeline); the controller ignores it and finishes the access.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the BASE_ADDR default and the half-word width constant 16;
  - an address-mapping function (byte address -> word index).
- Sub-module: sram_phase_counter, a loadable down-counter with a zero flag. Optional; inline is acceptable.
- Bench uses a behavioural SRAM model with 2^SRAM_AW half-words.

Test Plan:
- Reset then idle → ready = 1, sram_we_n = 1, oe = 0, rdata = 0 held over 10 cycles.
- Write 0xDEADBEEF at address 1028, W = 2:
  - ready = 0 on cycles 0–4, 1 on cycle 5.
  - SRAM addr 2 = 0xBEEF and addr 3 = 0xDEAD; we_n low on cycles 1–4.
- Read back address 1028 → rdata = 0xDEADBEEF when ready rises at cycle 5; oe stays 0 throughout.
- MEM_R_EN and MEM_W_EN both high with wdata 0x12345678 at address 1024 → performed as a write; rdata unchanged.
- rst pulsed during the HI phase of a write → next cycle IDLE, ready = 1, we_n = 1; a following write completes normally.
- W = 1 build, two back-to-back reads at 1024/1032 → ready low for 3 cycles each with a 1-cycle gap; both data words correct.
